twu_arbiter: RTL and testbench

- Shares the single table-walk unit (TWU) between the instruction-side TLB and the data-side TLB.
- Latches the winning miss request and holds it stable for the whole walk.
- Returns the walked PTE to the requester that owns the walk, and discards walks that a fence flush has invalidated.
- The D-side has priority, and a starvation guard bounds how long the I-side waits.

---
 rtl/twu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_twu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twu_arbiter.sv
// twu_arbiter
//   Shares one table-walk unit (TWU) between the I-side and D-side TLBs.
//   The winning miss VA is latched and held on walk_va for the whole walk,
//   and the walked PTE is returned to the side that owns the walk. A fence
//   flush discards any in-flight walk; because the TWU cannot be aborted, a
//   flushed walk is drained (walk_req held) until the TWU reports completion.
//   The D side has priority. A starvation counter forces an I grant after
//   STARVE_LIMIT consecutive D grants that happened while I was waiting.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   flush                fence flush
//   req_i / va_i         I-TLB miss request (level) and VA
//   rvalid_i / rdata_i   one-cycle completion pulse and PTE for the I-TLB
//   req_d / va_d         D-TLB miss request (level) and VA
//   rvalid_d / rdata_d   one-cycle completion pulse and PTE for the D-TLB
//   walk_req / walk_va   request and latched VA presented to the TWU
//   walk_pte             PTE from the TWU
//   walk_finish          TWU completion pulse
//   busy                 high whenever a walk (or drain) is in progress
//   owner                00 none, 01 I, 10 D, 11 draining
module twu_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] va_i,
  output logic                  rvalid_i,
  output logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  req_d,
  input  logic [ADDR_WIDTH-1:0] va_d,
  output logic                  rvalid_d,
  output logic [DATA_WIDTH-1:0] rdata_d,
  output logic                  walk_req,
  output logic [ADDR_WIDTH-1:0] walk_va,
  input  logic [DATA_WIDTH-1:0] walk_pte,
  input  logic                  walk_finish,
  output logic                  busy,
  output logic [1:0]            owner
);

  // State encoding equals the owner code, so owner is a direct register view.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WALK_I = 2'b01,
    WALK_D = 2'b10,
    DRAIN  = 2'b11
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] latched_va_q, latched_va_d;
  logic [3:0]            starve_q, starve_d;
  logic                  rvalid_i_q, rvalid_i_d;
  logic                  rvalid_d_q, rvalid_d_d;
  logic [DATA_WIDTH-1:0] rdata_i_q, rdata_i_d;
  logic [DATA_WIDTH-1:0] rdata_d_q, rdata_d_d;

  // Registered state; every output is taken from these flops so the TWU
  // and both TLBs see glitch-free, stable values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      latched_va_q <= '0;
      starve_q     <= '0;
      rvalid_i_q   <= 1'b0;
      rvalid_d_q   <= 1'b0;
      rdata_i_q    <= '0;
      rdata_d_q    <= '0;
    end else begin
      state_q      <= state_d;
      latched_va_q <= latched_va_d;
      starve_q     <= starve_d;
      rvalid_i_q   <= rvalid_i_d;
      rvalid_d_q   <= rvalid_d_d;
      rdata_i_q    <= rdata_i_d;
      rdata_d_q    <= rdata_d_d;
    end
  end

  // Arbitration and walk tracking. Completion always returns to IDLE, which
  // gives the requester the rvalid cycle to drop its request before the
  // next arbitration sees it.
  always_comb begin
    state_d      = state_q;
    latched_va_d = latched_va_q;
    starve_d     = starve_q;
    rvalid_i_d   = 1'b0;
    rvalid_d_d   = 1'b0;
    rdata_i_d    = rdata_i_q;
    rdata_d_d    = rdata_d_q;

    case (state_q)
      IDLE: begin
        if (flush) begin
          starve_d = '0;
        end else if (req_d && !(req_i && starve_q == LIMIT)) begin
          state_d      = WALK_D;
          latched_va_d = va_d;
          // Only D wins that leave I waiting count towards starvation.
          if (req_i) begin
            starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
          end else begin
            starve_d = '0;
          end
        end else if (req_i) begin
          state_d      = WALK_I;
          latched_va_d = va_i;
          starve_d     = '0;
        end
      end

      WALK_I: begin
        if (walk_finish) begin
          state_d = IDLE;
          if (!flush) begin
            rvalid_i_d = 1'b1;
            rdata_i_d  = walk_pte;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end

      WALK_D: begin
        if (walk_finish) begin
          state_d = IDLE;
          if (!flush) begin
            rvalid_d_d = 1'b1;
            rdata_d_d  = walk_pte;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (walk_finish) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign walk_req = (state_q != IDLE);
  assign owner    = state_q;
  assign walk_va  = latched_va_q;
  assign rvalid_i = rvalid_i_q;
  assign rvalid_d = rvalid_d_q;
  assign rdata_i  = rdata_i_q;
  assign rdata_d  = rdata_d_q;

endmodule

// File: tb/tb_twu_arbiter.sv
// tb_twu_arbiter
//   Drives twu_arbiter with directed scenarios followed by random traffic.
//   A transaction-level reference model predicts grants, ownership and
//   completions; predicted completions are queued and a separate monitor
//   pops them whenever the DUT raises rvalid_i or rvalid_d.
module tb_twu_arbiter;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          req_i, req_d;
  logic [AW-1:0] va_i, va_d;
  logic          rvalid_i, rvalid_d;
  logic [DW-1:0] rdata_i, rdata_d;
  logic          walk_req;
  logic [AW-1:0] walk_va;
  logic [DW-1:0] walk_pte;
  logic          walk_finish;
  logic          busy;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  twu_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_i(req_i), .va_i(va_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .req_d(req_d), .va_d(va_d), .rvalid_d(rvalid_d), .rdata_d(rdata_d),
    .walk_req(walk_req), .walk_va(walk_va), .walk_pte(walk_pte),
    .walk_finish(walk_finish), .busy(busy), .owner(owner)
  );

  int tests    = 0;
  int failures = 0;

  // Expected completions: side 1 = I, side 2 = D.
  typedef struct {
    int            side;
    logic [DW-1:0] pte;
  } exp_t;
  exp_t expQ[$];

  // Reference model: who holds the TWU (0 none, 1 I, 2 D, 3 discarded walk
  // still running), last latched VA, D wins while I waited, and which side
  // receives a result on the coming edge.
  int            mHolder = 0;
  logic [AW-1:0] mVa     = '0;
  int            mWaitWins = 0;
  bit            mRvI = 0, mRvD = 0;

  int twuCnt = 0, twuDelay = 3;

  task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every cycle-visible output with the model.
  task automatic checkOutput();
    checkVal("owner", 64'(owner), 64'(mHolder));
    checkVal("busy", 64'(busy), 64'(mHolder != 0));
    checkVal("walk_req", 64'(walk_req), 64'(mHolder != 0));
    checkVal("walk_va", walk_va, mVa);
    checkVal("rvalid_i", 64'(rvalid_i), 64'(mRvI));
    checkVal("rvalid_d", 64'(rvalid_d), 64'(mRvD));
  endtask

  // Predict the effect of the current inputs at the next rising edge.
  task automatic modelStep();
    mRvI = 0;
    mRvD = 0;
    if (mHolder == 0) begin
      if (flush) begin
        mWaitWins = 0;
      end else if (req_d && !(req_i && mWaitWins == LIMIT)) begin
        mHolder   = 2;
        mVa       = va_d;
        mWaitWins = req_i ? ((mWaitWins < LIMIT) ? mWaitWins + 1 : LIMIT) : 0;
      end else if (req_i) begin
        mHolder   = 1;
        mVa       = va_i;
        mWaitWins = 0;
      end
    end else if (walk_finish) begin
      if (mHolder != 3 && !flush) begin
        if (mHolder == 1) mRvI = 1;
        else              mRvD = 1;
        expQ.push_back('{mHolder, walk_pte});
      end
      mHolder = 0;
    end else if (flush && mHolder != 3) begin
      mHolder = 3;
    end
  endtask

  // One clock: model predicts, DUT clocks, outputs compared on the falling
  // edge. Requesters drop their request on seeing their rvalid; one-cycle
  // pulses are cleared afterwards.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
    if (mRvI) req_i = 1'b0;
    if (mRvD) req_d = 1'b0;
    walk_finish = 1'b0;
    flush       = 1'b0;
  endtask

  // Let the current walk run for 'cycles' cycles, finishing in the last one.
  task automatic waitWalk(int cycles, logic [DW-1:0] pte);
    repeat (cycles - 1) applyStimulus();
    walk_finish = 1'b1;
    walk_pte    = pte;
    applyStimulus();
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Scoreboard monitor: every rvalid must match the oldest predicted result.
  always @(posedge clk) begin
    #1;
    if (!rst && (rvalid_i || rvalid_d)) begin
      if (rvalid_i && rvalid_d) begin
        tests++;
        failures++;
        $display("[TB] FAIL rvalid_both: got 1 and 1 expected at most one");
      end else if (expQ.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected_rvalid: got rvalid_i=%0b rvalid_d=%0b expected none",
                 rvalid_i, rvalid_d);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkVal("sb_side", 64'(rvalid_d ? 2 : 1), 64'(e.side));
        checkVal("sb_pte", rvalid_d ? rdata_d : rdata_i, e.pte);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; req_i = 1'b0; req_d = 1'b0;
    va_i = '0; va_d = '0; walk_pte = '0; walk_finish = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput();
    checkVal("reset_rdata_i", rdata_i, 64'h0);
    checkVal("reset_rdata_d", rdata_d, 64'h0);

    // Single I miss.
    req_i = 1'b1; va_i = 64'h8000_1234;
    applyStimulus();
    checkVal("single_walk_va", walk_va, 64'h8000_1234);
    va_i = 64'hDEAD_BEEF;
    waitWalk(5, 64'h2000_00CF);
    checkVal("single_rdata_i", rdata_i, 64'h2000_00CF);
    applyStimulus();
    checkVal("single_owner_idle", 64'(owner), 64'h0);
    checkVal("single_rdata_hold", rdata_i, 64'h2000_00CF);

    // Simultaneous misses: D first, then I.
    req_i = 1'b1; va_i = 64'h1111_0000;
    req_d = 1'b1; va_d = 64'h2222_0000;
    applyStimulus();
    checkVal("simul_owner_d", 64'(owner), 64'h2);
    waitWalk(3, 64'hAAAA_0001);
    applyStimulus();
    checkVal("simul_owner_i", 64'(owner), 64'h1);
    waitWalk(2, 64'hBBBB_0002);

    // Starvation: four D walks while I waits, then I is forced through.
    req_i = 1'b1; va_i = 64'h3333_0000;
    for (int k = 0; k < LIMIT; k++) begin
      req_d = 1'b1; va_d = 64'h4444_0000 + 64'(k);
      applyStimulus();
      checkVal("starve_d_grant", 64'(owner), 64'h2);
      waitWalk(2, 64'h5555_0000 + 64'(k));
    end
    req_d = 1'b1; va_d = 64'h4444_00FF;
    applyStimulus();
    checkVal("starve_i_grant", 64'(owner), 64'h1);
    waitWalk(2, 64'h6666_0000);
    applyStimulus();
    waitWalk(2, 64'h6666_0001);

    // Flush in the 2nd cycle of WALK_I; TWU finishes 3 cycles later.
    req_i = 1'b1; va_i = 64'h7777_0000;
    applyStimulus();
    applyStimulus();
    flush = 1'b1;
    applyStimulus();
    checkVal("drain_owner", 64'(owner), 64'h3);
    applyStimulus();
    applyStimulus();
    walk_finish = 1'b1; walk_pte = 64'hBAD0_0001;
    applyStimulus();
    checkVal("drain_no_rvalid", 64'(rvalid_i), 64'h0);
    applyStimulus();
    waitWalk(2, 64'h7777_0001);

    // Flush together with walk_finish in WALK_D, then flush in IDLE.
    req_d = 1'b1; va_d = 64'h8888_0000;
    applyStimulus();
    applyStimulus();
    flush = 1'b1; walk_finish = 1'b1; walk_pte = 64'hBAD0_0002;
    applyStimulus();
    checkVal("flush_finish_no_rvalid", 64'(rvalid_d), 64'h0);
    flush = 1'b1;
    applyStimulus();
    checkVal("idle_flush_no_grant", 64'(owner), 64'h0);
    applyStimulus();
    checkVal("post_flush_grant_d", 64'(owner), 64'h2);
    waitWalk(1, 64'h8888_0001);

    // walk_finish while idle is ignored.
    applyStimulus();
    walk_finish = 1'b1; walk_pte = 64'hBAD0_0003;
    applyStimulus();

    // Reset in the middle of a D walk.
    req_d = 1'b1; va_d = 64'h9999_0000;
    applyStimulus();
    applyStimulus();
    rst = 1'b1;
    #1;
    checkVal("rst_busy", 64'(busy), 64'h0);
    checkVal("rst_owner", 64'(owner), 64'h0);
    checkVal("rst_walk_req", 64'(walk_req), 64'h0);
    checkVal("rst_walk_va", walk_va, 64'h0);
    checkVal("rst_rdata_d", rdata_d, 64'h0);
    mHolder = 0; mVa = '0; mWaitWins = 0; mRvI = 0; mRvD = 0;
    req_d = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus();

    // Random traffic.
    twuCnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!req_i && $urandom_range(0, 3) == 0) begin req_i = 1'b1; va_i = rand64(); end
      if (!req_d && $urandom_range(0, 3) == 0) begin req_d = 1'b1; va_d = rand64(); end
      if (req_i && $urandom_range(0, 9) == 0) va_i = rand64();
      if (req_d && $urandom_range(0, 9) == 0) va_d = rand64();
      if (mHolder != 0) begin
        twuCnt++;
        if (twuCnt >= twuDelay) begin
          walk_finish = 1'b1;
          walk_pte    = rand64();
          twuCnt      = 0;
          twuDelay    = $urandom_range(1, 6);
        end
      end else begin
        twuCnt = 0;
      end
      flush = ($urandom_range(0, 19) == 0);
      applyStimulus();
    end

    // Drain remaining requests without raising new ones.
    for (int c = 0; c < 100; c++) begin
      if (mHolder != 0) begin
        twuCnt++;
        if (twuCnt >= 2) begin
          walk_finish = 1'b1;
          walk_pte    = rand64();
          twuCnt      = 0;
        end
      end
      applyStimulus();
    end
    @(posedge clk);
    #2;
    checkVal("sb_empty", 64'(expQ.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
